// File: rtl/agu_seq.sv
// Job sequencer for one AGU: latches a descriptor, clears the AGU once, then
// steps it per accepted address on a valid/ready stream toward the memory port.
module agu_seq #(
  parameter int BWADDR   = 21,
  parameter int BWLENGTH = 8,
  parameter int BWCOUNT  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [4*BWLENGTH-1:0] cfg_l,
  input  logic [5*BWADDR-1:0]   cfg_j,
  input  logic [BWCOUNT-1:0]    cfg_cnt,
  output logic                  busy,
  output logic                  done,
  output logic [BWCOUNT-1:0]    remaining,
  output logic                  agu_clr,
  output logic                  agu_step,
  output logic [4*BWLENGTH-1:0] agu_l,
  output logic [5*BWADDR-1:0]   agu_j,
  input  logic [BWADDR-1:0]     agu_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BWADDR-1:0]     out_addr,
  output logic                  out_last
);

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

  typedef struct packed {
    logic [4*BWLENGTH-1:0] l;
    logic [5*BWADDR-1:0]   j;
  } job_t;

  state_t             state, state_nx;
  job_t               job_q;
  logic [BWCOUNT-1:0] rem_q, rem_nx;
  logic               load, hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rem_q <= '0;
      job_q <= '0;
    end else begin
      state <= state_nx;
      rem_q <= rem_nx;
      if (load) job_q <= {cfg_l, cfg_j};
    end
  end

  always_comb begin
    state_nx  = state;
    rem_nx    = rem_q;
    load      = 1'b0;
    hs        = 1'b0;
    agu_clr   = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          rem_nx   = cfg_cnt;
          state_nx = (cfg_cnt == '0) ? DONE : CLR;
        end
      end
      CLR: begin
        // an abort here skips the clear; the next job's CLR reinitialises the AGU
        if (abort) begin
          state_nx = IDLE;
          rem_nx   = '0;
        end else begin
          agu_clr  = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        out_valid = 1'b1;
        if (abort) begin
          state_nx = IDLE;
          rem_nx   = '0;
        end else if (out_ready) begin
          hs = 1'b1;
          if (rem_q != '0) rem_nx = rem_q - BWCOUNT'(1);
          if (rem_q <= BWCOUNT'(1)) state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign remaining = rem_q;
  assign agu_step  = hs;
  assign agu_l     = job_q.l;
  assign agu_j     = job_q.j;
  assign out_addr  = out_valid ? agu_addr : '0;
  assign out_last  = out_valid && (rem_q == BWCOUNT'(1));

  a_clr_step_mutex: assert property (@(posedge clk) disable iff (rst) !(agu_clr && agu_step));
  a_step_in_run:    assert property (@(posedge clk) disable iff (rst) agu_step |-> state == RUN);

endmodule
